// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbitration controller.
// Supplies default geometry macros when the build does not define them.
`ifndef RFSZLOG2
`define RFSZLOG2 4
`endif
`ifndef WORDSZ
`define WORDSZ 16
`endif

package sram_arb_pkg;
  localparam int SRAM_RD_LAT = 3;
  localparam int NREQ_DEF = 4;

  typedef logic [$clog2(NREQ_DEF)-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    zero;
  } rd_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, searching from a registered pointer
// that moves to the requester after the last one granted.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  int            idx;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        ptr_nxt  = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (advance && found)
      ptr <= ptr_nxt;
  end
endmodule

// File: rtl/sram_mxn.sv
// Single read-port / single write-port SRAM: 3-cycle registered read,
// write lands two edges after issue; word 0 clears on any cycle without a write.
module sram_mxn #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              ren_p0;
  logic [ADDR_W-1:0] raddr_p0;
  logic              wen_p0;
  logic [ADDR_W-1:0] waddr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] rd_p1;

  always_ff @(posedge clk) begin
    ren_p0   <= ren;
    raddr_p0 <= raddr;
    wen_p0   <= wen;
    waddr_p0 <= waddr;
    wdata_p0 <= wdata;
    // array read and write share an edge, so a read sees the pre-write word
    if (ren_p0)
      rd_p1 <= mem[raddr_p0];
    rdata <= rd_p1;
    if (wen_p0)
      mem[waddr_p0] <= wdata_p0;
    else
      mem[0] <= '0;
  end
endmodule

// File: rtl/sram_arb_ctrl.sv
// Round-robin read/write arbitration onto one sram_mxn with tagged responses
// and a shadow register for word 0. SRAM_ARB_RAW_STALL_EN holds same-address reads.
module sram_arb_ctrl
  import sram_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int ADDR_W = `RFSZLOG2,
  parameter int DATA_W = `WORDSZ
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             rd_req_i,
  input  logic [NREQ-1:0][ADDR_W-1:0] rd_addr_i,
  output logic [NREQ-1:0]             rd_gnt_o,
  input  logic [NREQ-1:0]             wr_req_i,
  input  logic [NREQ-1:0][ADDR_W-1:0] wr_addr_i,
  input  logic [NREQ-1:0][DATA_W-1:0] wr_data_i,
  output logic [NREQ-1:0]             wr_gnt_o,
  output logic [NREQ-1:0]             rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_data_o,
  output logic                        busy_o
);
  logic [NREQ-1:0]   rd_gnt_raw, wr_gnt_raw, rd_elig;
  logic              rd_any, wr_any;
  req_id_t           rd_id, wr_id;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] wr_data, shadow, sram_rdata;
  rd_tag_t           tag_new;
  rd_tag_t           tag_p [SRAM_RD_LAT];
  logic [DATA_W-1:0] sh_p  [SRAM_RD_LAT];

  rr_arbiter #(.N(NREQ)) u_wr_arb (
    .clk(clk), .rst_n(rst_n), .req(wr_req_i), .advance(wr_any), .gnt(wr_gnt_raw)
  );

  assign wr_gnt_o = rst_n ? wr_gnt_raw : '0;
  assign wr_any   = |wr_gnt_o;

  always_comb begin
    wr_id = '0;
    for (int i = 0; i < NREQ; i++)
      if (wr_gnt_o[i]) wr_id = req_id_t'(i);
  end

  assign wr_addr = wr_addr_i[wr_id];
  assign wr_data = wr_data_i[wr_id];

`ifdef SRAM_ARB_RAW_STALL_EN
  logic [NREQ-1:0] raw_hit;

  always_comb begin
    raw_hit = '0;
    for (int i = 0; i < NREQ; i++)
      raw_hit[i] = wr_any && (rd_addr_i[i] == wr_addr);
  end

  assign rd_elig = rd_req_i & ~raw_hit;
`else
  assign rd_elig = rd_req_i;
`endif

  rr_arbiter #(.N(NREQ)) u_rd_arb (
    .clk(clk), .rst_n(rst_n), .req(rd_elig), .advance(rd_any), .gnt(rd_gnt_raw)
  );

  assign rd_gnt_o = rst_n ? rd_gnt_raw : '0;
  assign rd_any   = |rd_gnt_o;

  always_comb begin
    rd_id = '0;
    for (int i = 0; i < NREQ; i++)
      if (rd_gnt_o[i]) rd_id = req_id_t'(i);
  end

  assign rd_addr = rd_addr_i[rd_id];

  always_comb begin
    tag_new.valid = rd_any;
    tag_new.id    = rd_id;
    tag_new.zero  = (rd_addr == '0);
  end

  sram_mxn #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_sram (
    .clk   (clk),
    .ren   (rd_any && !tag_new.zero),
    .raddr (rd_addr),
    .wen   (wr_any && (wr_addr != '0)),
    .waddr (wr_addr),
    .wdata (wr_data),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shadow <= '0;
    else if (wr_any && (wr_addr == '0))
      shadow <= wr_data;
  end

  // Stage boundary: tag and shadow value captured at the grant edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SRAM_RD_LAT; s++) tag_p[s] <= '0;
    end else begin
      tag_p[0] <= tag_new;
      for (int s = 1; s < SRAM_RD_LAT; s++) tag_p[s] <= tag_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    sh_p[0] <= shadow;
    for (int s = 1; s < SRAM_RD_LAT; s++) sh_p[s] <= sh_p[s-1];
  end

  // Stage boundary: response presented from the last tag stage
  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NREQ; i++)
      if (tag_p[SRAM_RD_LAT-1].valid && tag_p[SRAM_RD_LAT-1].id == req_id_t'(i))
        rsp_valid_o[i] = 1'b1;
    if (!tag_p[SRAM_RD_LAT-1].valid)
      rsp_data_o = '0;
    else if (tag_p[SRAM_RD_LAT-1].zero)
      rsp_data_o = sh_p[SRAM_RD_LAT-1];
    else
      rsp_data_o = sram_rdata;
  end

  always_comb begin
    busy_o = rd_any;
    for (int s = 0; s < SRAM_RD_LAT; s++)
      busy_o = busy_o | tag_p[s].valid;
  end
endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl: grants are checked per cycle, read
// responses are queued at grant time and matched by an independent monitor.
module tb_sram_arb_ctrl;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         rd_req, wr_req;
  logic [N-1:0][AW-1:0] rd_addr, wr_addr;
  logic [N-1:0][DW-1:0] wr_data;
  logic [N-1:0]         rd_gnt, wr_gnt, rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 busy;

  sram_arb_ctrl #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  vld;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            total = 0;
  int            bad = 0;
  int            cyc_cnt = 0;
  logic [DW-1:0] ref_mem [2**AW];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  function automatic int id_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++)
      if (g[i]) return i;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (rst_n && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got valid %b data %0h expected no response", rsp_valid, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(mon_e.vld));
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        chk("rsp_cycle", cyc_cnt, mon_e.cyc);
      end
    end
  end

  // Check grants in the current cycle, queue the read's expected response,
  // update the write model, then move to just after the next edge.
  task automatic step(input logic [N-1:0] erg, input logic [N-1:0] ewg,
                      input bit use_model, input logic [DW-1:0] d);
    exp_t e;
    int   rid, wid;
    @(negedge clk);
    chk("rd_gnt", 32'(rd_gnt), 32'(erg));
    chk("wr_gnt", 32'(wr_gnt), 32'(ewg));
    if (rd_gnt != '0) begin
      rid = id_of(rd_gnt);
      e.vld = '0;
      e.vld[rid] = 1'b1;
      e.data = use_model ? ref_mem[rd_addr[rid]] : d;
      e.cyc = cyc_cnt + 3;
      sb.push_back(e);
    end
    if (wr_gnt != '0) begin
      wid = id_of(wr_gnt);
      ref_mem[wr_addr[wid]] = wr_data[wid];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    chk("drain_before_reset", sb.size(), 0);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_req = '1;
    wr_req = '1;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    #2;
    chk("rst_rd_gnt", 32'(rd_gnt), 0);
    chk("rst_wr_gnt", 32'(wr_gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    rd_req = '0;
    wr_req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // write A5 to address 5, read it back two cycles later
    wr_req = 4'b0010; wr_addr[1] = 4'd5; wr_data[1] = 16'h00A5;
    step(4'b0000, 4'b0010, 1'b0, '0);
    wr_req = '0;
    step(4'b0000, 4'b0000, 1'b0, '0);
    rd_req = 4'b0100; rd_addr[2] = 4'd5;
    step(4'b0100, 4'b0000, 1'b0, 16'h00A5);
    rd_req = '0;
    idle(4);

    // all four read continuously: rotation 0,1,2,3 from a fresh pointer
    do_reset();
    rd_req = '1;
    for (int i = 0; i < N; i++) rd_addr[i] = 4'd5;
    for (int k = 0; k < 8; k++) begin
      step(4'(1 << (k % 4)), 4'b0000, 1'b0, 16'h00A5);
      chk("busy_stream", 32'(busy), 1);
    end
    rd_req = '0;
    idle(4);

    // shadow word 0 survives idle cycles
    wr_req = 4'b0001; wr_addr[0] = 4'd0; wr_data[0] = 16'h1234;
    step(4'b0000, 4'b0001, 1'b0, '0);
    wr_req = '0;
    idle(10);
    rd_req = 4'b1000; rd_addr[3] = 4'd0;
    step(4'b1000, 4'b0000, 1'b0, 16'h1234);
    rd_req = '0;
    idle(4);

    // same-cycle write and read of address 9 (old value 0x11)
    wr_req = 4'b0001; wr_addr[0] = 4'd9; wr_data[0] = 16'h0011;
    step(4'b0000, 4'b0001, 1'b0, '0);
    wr_req = '0;
    idle(2);
    wr_req = 4'b0010; wr_addr[1] = 4'd9; wr_data[1] = 16'h0077;
    rd_req = 4'b0100; rd_addr[2] = 4'd9;
`ifdef SRAM_ARB_RAW_STALL_EN
    step(4'b0000, 4'b0010, 1'b0, '0);
    wr_req = '0;
    step(4'b0100, 4'b0000, 1'b0, 16'h0077);
`else
    step(4'b0100, 4'b0010, 1'b0, 16'h0011);
`endif
    rd_req = '0;
    wr_req = '0;
    idle(4);

    // same-cycle write and read of shadow word 0 (old value 0x1234)
    wr_req = 4'b0100; wr_addr[2] = 4'd0; wr_data[2] = 16'h0055;
    rd_req = 4'b0010; rd_addr[1] = 4'd0;
`ifdef SRAM_ARB_RAW_STALL_EN
    step(4'b0000, 4'b0100, 1'b0, '0);
    wr_req = '0;
    step(4'b0010, 4'b0000, 1'b0, 16'h0055);
`else
    step(4'b0010, 4'b0100, 1'b0, 16'h1234);
`endif
    rd_req = '0;
    wr_req = '0;
    idle(4);

    // reads at T, T+1, T+2 then reset: all in-flight reads dropped
    chk("drain_before_t5", sb.size(), 0);
    for (int i = 0; i < N; i++) rd_addr[i] = 4'd5;
    rd_req = 4'b0001;
    step(4'b0001, 4'b0000, 1'b0, 16'h00A5);
    rd_req = 4'b0010;
    step(4'b0010, 4'b0000, 1'b0, 16'h00A5);
    rd_req = 4'b0100;
    @(negedge clk);
    chk("rd_gnt_t2", 32'(rd_gnt), 32'(4'b0100));
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_busy_mid", 32'(busy), 0);
    chk("rst_rsp_mid", 32'(rsp_valid), 0);
    chk("rst_rd_gnt_mid", 32'(rd_gnt), 0);
    rd_req = '1;
    wr_req = '1;
    for (int i = 0; i < N; i++) begin
      wr_addr[i] = 4'd12;
      wr_data[i] = 16'hC000 + 16'(i);
    end
    @(posedge clk);
    #1;
    chk("rst_rsp_hold", 32'(rsp_valid), 0);
    chk("rst_busy_hold", 32'(busy), 0);
    chk("rst_wr_gnt_hold", 32'(wr_gnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b0001, 4'b0001, 1'b0, 16'h00A5);
    rd_req = '0;
    wr_req = '0;
    idle(4);

    // concurrent streams: reads of 1..4, writes of 8..11
    wr_req = 4'b0001;
    for (int i = 0; i < N; i++) begin
      wr_addr[0] = 4'(i + 1);
      wr_data[0] = 16'hB000 + 16'(i);
      step(4'b0000, 4'b0001, 1'b0, '0);
    end
    wr_req = '0;
    idle(1);
    rd_req = '1;
    wr_req = '1;
    for (int i = 0; i < N; i++) begin
      rd_addr[i] = 4'(i + 1);
      wr_addr[i] = 4'(i + 8);
    end
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < N; i++) wr_data[i] = 16'h6000 + 16'(k * 16 + i);
      step(4'(1 << ((k + 1) % 4)), 4'(1 << ((k + 1) % 4)), 1'b1, '0);
    end
    rd_req = '0;
    wr_req = '0;
    idle(5);
    chk("final_drain", sb.size(), 0);
    chk("final_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
